// File: rtl/q_learning_pkg.sv
// Shared constants, FSM encoding and binary32 helpers for the Q-learning engine.
package q_learning_pkg;
    localparam int DATA_WIDTH    = 32;
    localparam int STATES_WIDTH  = 4;
    localparam int ACTIONS_WIDTH = 2;
    localparam int N_STATES      = 1 << STATES_WIDTH;
    localparam int N_ACTIONS     = 1 << ACTIONS_WIDTH;
    localparam int N_ENTRIES     = N_STATES * N_ACTIONS;
    localparam int ALPHA_SHIFT   = 1;
    localparam int GAMMA_SHIFT   = 1;
    localparam int EXP_BIAS      = 127;
    localparam int EXP_WIDTH     = 8;
    localparam int FRAC_WIDTH    = 23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAX,
        ST_ADD1,
        ST_SUB,
        ST_ADD2
    } state_t;

    // Multiply by 2**-k via exponent decrement; anything that would go subnormal becomes +0.
    function automatic logic [DATA_WIDTH-1:0] fp_scale(input logic [DATA_WIDTH-1:0] x, input int k);
        fp_scale = '0;
        if (int'(x[30:23]) > k)
            fp_scale = {x[31], x[30:23] - EXP_WIDTH'(k), x[22:0]};
    endfunction

    // Maps binary32 onto an unsigned key whose ordering matches numeric ordering; +0 and -0 collapse.
    function automatic logic [DATA_WIDTH-1:0] fp_order_key(input logic [DATA_WIDTH-1:0] x);
        if (x[30:0] == '0)
            fp_order_key = 32'h8000_0000;
        else if (x[31])
            fp_order_key = ~x;
        else
            fp_order_key = x | 32'h8000_0000;
    endfunction
endpackage

// File: rtl/q_learning_fp_add32.sv
// Combinational binary32 adder/subtractor: flush-to-zero inputs, round toward zero.
module fp_add32
    import q_learning_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sub,
    output logic [DATA_WIDTH-1:0] y
);
    logic [30:0]       mag_a, mag_b, mag_x, mag_y;
    logic              sign_b, sign_x, sign_y;
    logic [7:0]        exp_x, exp_y, diff;
    logic [23:0]       man_x, man_y;
    logic [53:0]       wide;
    logic [26:0]       aligned;
    logic [27:0]       sum;
    logic [26:0]       norm;
    logic [4:0]        lead, shift;
    logic signed [9:0] exp_res;
    logic [22:0]       frac;

    always_comb begin
        mag_a  = (a[30:23] == '0) ? '0 : a[30:0];
        mag_b  = (b[30:23] == '0) ? '0 : b[30:0];
        sign_b = b[31] ^ sub;
        if (mag_a >= mag_b) begin
            mag_x = mag_a; sign_x = a[31];
            mag_y = mag_b; sign_y = sign_b;
        end else begin
            mag_x = mag_b; sign_x = sign_b;
            mag_y = mag_a; sign_y = a[31];
        end
        exp_x = mag_x[30:23];
        exp_y = mag_y[30:23];
        man_x = (exp_x == '0) ? '0 : {1'b1, mag_x[22:0]};
        man_y = (exp_y == '0) ? '0 : {1'b1, mag_y[22:0]};
        diff  = exp_x - exp_y;

        // Guard/round/sticky: bit 0 of the aligned operand collects every bit shifted past it.
        wide    = {man_y, 3'b000, 27'd0} >> diff;
        aligned = wide[53:27] | {26'd0, (diff >= 8'd27) ? |man_y : |wide[26:0]};

        if (sign_x == sign_y)
            sum = {1'b0, man_x, 3'b000} + {1'b0, aligned};
        else
            sum = {1'b0, man_x, 3'b000} - {1'b0, aligned};

        lead = '0;
        for (int i = 0; i < 27; i++)
            if (sum[i]) lead = 5'(i);
        shift = 5'd26 - lead;
        norm  = sum[26:0] << shift;

        if (sum[27]) begin
            exp_res = $signed({2'b00, exp_x}) + 10'sd1;
            frac    = 23'(sum >> 4);
        end else begin
            exp_res = $signed({2'b00, exp_x}) - $signed({5'd0, shift});
            frac    = 23'(norm >> 3);
        end

        if (sum == '0 || exp_res <= 10'sd0)
            y = '0;
        else if (exp_res >= 10'sd255)
            y = {sign_x, 8'hFF, 23'd0};
        else
            y = {sign_x, exp_res[7:0], frac};
    end
endmodule

// File: rtl/q_learning.sv
// Tabular Q-learning update engine: five-state pipeline sharing one binary32 adder.
module q_learning
    import q_learning_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    input  logic                     i_write_file_en,
    input  logic [STATES_WIDTH-1:0]  i_st,
    input  logic [STATES_WIDTH-1:0]  i_next_st,
    input  logic [ACTIONS_WIDTH-1:0] i_at,
    input  logic [DATA_WIDTH-1:0]    i_rt,
    output logic [ACTIONS_WIDTH-1:0] o_at_max,
    output logic                     o_valid
);
    state_t                   state_reg, state_next;
    logic [STATES_WIDTH-1:0]  st_reg, next_st_reg;
    logic [ACTIONS_WIDTH-1:0] at_reg, idx_reg, max_idx;
    logic [DATA_WIDTH-1:0]    rt_reg, qsa_reg, qmax_reg, t_reg, max_val;
    logic [DATA_WIDTH-1:0]    q_table [N_ENTRIES];
    logic [DATA_WIDTH-1:0]    row [N_ACTIONS];
    logic [DATA_WIDTH-1:0]    add_a, add_b, add_y;
    logic                     add_sub;

    genvar gi;
    generate
        for (gi = 0; gi < N_ACTIONS; gi++) begin : g_row
            assign row[gi] = q_table[{next_st_reg, ACTIONS_WIDTH'(gi)}];
        end
    endgenerate

    // Strictly-greater replacement keeps the lowest index on ties.
    always_comb begin
        max_val = row[0];
        max_idx = '0;
        for (int i = 1; i < N_ACTIONS; i++) begin
            if (fp_order_key(row[i]) > fp_order_key(max_val)) begin
                max_val = row[i];
                max_idx = ACTIONS_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (i_valid) state_next = ST_MAX;
            ST_MAX:  state_next = ST_ADD1;
            ST_ADD1: state_next = ST_SUB;
            ST_SUB:  state_next = ST_ADD2;
            ST_ADD2: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        case (state_reg)
            ST_ADD1: begin add_a = rt_reg;  add_b = fp_scale(qmax_reg, GAMMA_SHIFT); end
            ST_SUB:  begin add_a = t_reg;   add_b = qsa_reg; add_sub = 1'b1; end
            ST_ADD2: begin add_a = qsa_reg; add_b = fp_scale(t_reg, ALPHA_SHIFT); end
            default: ;
        endcase
    end

    fp_add32 u_add (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .y   (add_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            st_reg      <= '0;
            next_st_reg <= '0;
            at_reg      <= '0;
            rt_reg      <= '0;
            qsa_reg     <= '0;
            qmax_reg    <= '0;
            idx_reg     <= '0;
            t_reg       <= '0;
            o_at_max    <= '0;
            o_valid     <= 1'b0;
            for (int i = 0; i < N_ENTRIES; i++)
                q_table[i] <= '0;
        end else begin
            state_reg <= state_next;
            o_valid   <= 1'b0;
            case (state_reg)
                ST_IDLE: if (i_valid) begin
                    st_reg      <= i_st;
                    next_st_reg <= i_next_st;
                    at_reg      <= i_at;
                    rt_reg      <= i_rt;
                    qsa_reg     <= q_table[{i_st, i_at}];
                end
                ST_MAX: begin
                    qmax_reg <= max_val;
                    idx_reg  <= max_idx;
                end
                ST_ADD1, ST_SUB: t_reg <= add_y;
                ST_ADD2: begin
                    q_table[{st_reg, at_reg}] <= add_y;
                    o_at_max <= idx_reg;
                    o_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    function automatic void dump_table();
        for (int i = 0; i < N_ENTRIES; i++)
            $display("q_table[%0d] = %08h", i, q_table[i]);
    endfunction

    always @(posedge clk)
        if (rst_n && state_reg == ST_IDLE && i_write_file_en)
            dump_table();
`endif
endmodule

// File: tb/tb_q_learning.sv
// Directed + randomized bench for q_learning against a real-arithmetic reference model.
module tb_q_learning;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_write_file_en = 1'b0;
    logic [3:0]  i_st = '0;
    logic [3:0]  i_next_st = '0;
    logic [1:0]  i_at = '0;
    logic [31:0] i_rt = '0;
    logic [1:0]  o_at_max;
    logic        o_valid;

    int checks = 0;
    int errors = 0;
    logic [31:0] mq [64];

    q_learning dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_valid         (i_valid),
        .i_write_file_en (i_write_file_en),
        .i_st            (i_st),
        .i_next_st       (i_next_st),
        .i_at            (i_at),
        .i_rt            (i_rt),
        .o_at_max        (o_at_max),
        .o_valid         (o_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    function automatic real pow2(input int e);
        real p = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) p = p * 2.0;
        else        for (int i = 0; i < -e; i++) p = p / 2.0;
        return p;
    endfunction

    function automatic real f2r(input logic [31:0] x);
        real m;
        if (x[30:23] == 8'd0) return 0.0;
        m = (1.0 + real'(x[22:0]) / 8388608.0) * pow2(int'(x[30:23]) - 127);
        return x[31] ? -m : m;
    endfunction

    // Exact real -> binary32 truncated toward zero, with +0 on underflow and inf on overflow.
    function automatic logic [31:0] r2f(input real v);
        real m;
        int e;
        logic sgn;
        if (v == 0.0) return 32'h0;
        sgn = (v < 0.0);
        m = sgn ? -v : v;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        if (e < -126) return 32'h0;
        if (e > 127)  return {sgn, 8'hFF, 23'h0};
        return {sgn, 8'(e + 127), 23'($rtoi((m - 1.0) * 8388608.0))};
    endfunction

    task automatic model_step(input int s, input int sn, input int a, input logic [31:0] r,
                              output logic [31:0] newq, output int idx);
        real best;
        logic [31:0] g, t2, t3, al, q;
        best = f2r(mq[sn*4]);
        idx = 0;
        for (int i = 1; i < 4; i++)
            if (f2r(mq[sn*4+i]) > best) begin best = f2r(mq[sn*4+i]); idx = i; end
        q    = mq[s*4+a];
        g    = r2f(best * 0.5);
        t2   = r2f(f2r(r) + f2r(g));
        t3   = r2f(f2r(t2) - f2r(q));
        al   = r2f(f2r(t3) * 0.5);
        newq = r2f(f2r(q) + f2r(al));
        mq[s*4+a] = newq;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mq[i] = 32'h0;
    endtask

    task automatic run_update(input int s, input int sn, input int a, input logic [31:0] r,
                              output logic [31:0] qn, output int idx);
        logic early;
        @(negedge clk);
        i_st = 4'(s); i_next_st = 4'(sn); i_at = 2'(a); i_rt = r; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_st = 4'($urandom); i_next_st = 4'($urandom); i_at = 2'($urandom); i_rt = $urandom;
        early = o_valid;
        repeat (3) begin @(negedge clk); early = early | o_valid; end
        @(negedge clk);
        model_step(s, sn, a, r, qn, idx);
        check("early_valid", 32'(early), 32'd0);
        check("valid_pulse", 32'(o_valid), 32'd1);
        check($sformatf("at_max s=%0d sn=%0d", s, sn), 32'(o_at_max), 32'(idx));
        check($sformatf("q[%0d][%0d]", s, a), dut.q_table[s*4+a], qn);
        $display("update s=%0d sn=%0d a=%0d r=%h -> q=%h at_max=%0d", s, sn, a, r, dut.q_table[s*4+a], o_at_max);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        clear_model();
    endtask

    initial begin
        logic [31:0] qn, acc, plan_q [3];
        int idx;
        logic bad;
        plan_q = '{32'h41C80000, 32'h42160000, 32'h422F0000};

        // Reset state
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        acc = '0;
        for (int i = 0; i < 64; i++) acc = acc | dut.q_table[i];
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_at_max", 32'(o_at_max), 32'd0);
        check("reset_table", acc, 32'd0);
        rst_n = 1'b1;

        // i_valid held high: completions every 5 cycles
        @(negedge clk);
        i_st = 4'd0; i_next_st = 4'd5; i_at = 2'd3; i_rt = 32'h42480000; i_valid = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check($sformatf("held_valid c%0d", k), 32'(o_valid), 32'((k % 5) == 4));
            if ((k % 5) == 4) begin
                model_step(0, 5, 3, 32'h42480000, qn, idx);
                check("held_q_model", dut.q_table[3], qn);
                check("held_q_plan", dut.q_table[3], plan_q[k/5]);
                check("held_at_max", 32'(o_at_max), 32'd0);
                $display("held update %0d -> q[0][3]=%h", k/5, dut.q_table[3]);
            end
        end
        i_valid = 1'b0;

        // Self-loop
        run_update(2, 2, 1, 32'h41200000, qn, idx);
        check("self1_q", dut.q_table[9], 32'h40A00000);
        check("self1_idx", 32'(o_at_max), 32'd0);
        run_update(2, 2, 1, 32'h41200000, qn, idx);
        check("self2_q", dut.q_table[9], 32'h410C0000);
        check("self2_idx", 32'(o_at_max), 32'd1);

        // Negative reward on fresh table
        pulse_reset();
        run_update(7, 8, 2, 32'hC1000000, qn, idx);
        check("neg_q", dut.q_table[30], 32'hC0800000);
        run_update(9, 7, 0, 32'h00000000, qn, idx);
        check("neg_idx", 32'(o_at_max), 32'd0);

        // Tie-breaking
        run_update(3, 10, 1, 32'h42480000, qn, idx);
        run_update(3, 10, 2, 32'h42480000, qn, idx);
        check("tie_q1", dut.q_table[13], 32'h41C80000);
        run_update(11, 3, 0, 32'h00000000, qn, idx);
        check("tie_idx", 32'(o_at_max), 32'd1);

        // i_valid while busy is ignored
        @(negedge clk);
        i_st = 4'd4; i_next_st = 4'd5; i_at = 2'd0; i_rt = 32'h41200000; i_valid = 1'b1;
        @(negedge clk);
        i_st = 4'd6; i_next_st = 4'd6; i_at = 2'd3; i_rt = 32'h42C80000;
        bad = o_valid;
        repeat (2) begin @(negedge clk); bad = bad | o_valid; end
        @(negedge clk);
        i_valid = 1'b0; bad = bad | o_valid;
        @(negedge clk);
        model_step(4, 5, 0, 32'h41200000, qn, idx);
        check("busy_early", 32'(bad), 32'd0);
        check("busy_pulse", 32'(o_valid), 32'd1);
        check("busy_qA", dut.q_table[16], qn);
        check("busy_qB", dut.q_table[27], mq[27]);
        bad = 1'b0;
        repeat (6) begin @(negedge clk); bad = bad | o_valid; end
        check("busy_no_second", 32'(bad), 32'd0);
        $display("busy test q[4][0]=%h q[6][3]=%h", dut.q_table[16], dut.q_table[27]);

        // Reset during SUB aborts the update
        @(negedge clk);
        i_st = 4'd1; i_next_st = 4'd0; i_at = 2'd1; i_rt = 32'h42480000; i_valid = 1'b1;
        @(negedge clk); i_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(o_valid), 32'd0);
        check("rst_mid_q11", dut.q_table[5], 32'd0);
        check("rst_mid_q31", dut.q_table[13], 32'd0);
        check("rst_mid_at_max", 32'(o_at_max), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        clear_model();
        bad = 1'b0;
        repeat (5) begin @(negedge clk); bad = bad | o_valid; end
        check("rst_mid_no_pulse", 32'(bad), 32'd0);
        run_update(1, 0, 1, 32'h42480000, qn, idx);
        check("rst_mid_restart", dut.q_table[5], 32'h41C80000);

        // Randomized transitions over a small state window to force interaction
        for (int n = 0; n < 40; n++) begin
            int s, sn, a, rv;
            s  = int'($urandom_range(0, 5));
            sn = int'($urandom_range(0, 5));
            a  = int'($urandom_range(0, 3));
            rv = int'($urandom_range(0, 128)) - 64;
            run_update(s, sn, a, r2f(real'(rv)), qn, idx);
        end

        for (int i = 0; i < 64; i++)
            check($sformatf("final q[%0d]", i), dut.q_table[i], mq[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
